result_display_sequencer: RTL
=============================

Name: result_display_sequencer

Overview:
- Upstream feeder for the 8-digit seven-segment driver in the MMA.
- Walks the MMA result memory one element at a time and fetches each word via a read handshake.
- Presents the word on a 32-bit hex bus and holds it for a programmable dwell before advancing.
- Runs in the 1 kHz slow_clk domain; supports pause and manual step from debounced board buttons.

Parameters:
- ADDR_W, 8, result memory address width (max 256 elements).
- DWELL, 1000, slow_clk ticks each element is shown (1 s at 1 kHz); must be >= 2.

Ports:
- slow_clk  in  1  block clock (1 kHz).
- reset  in  1  synchronous, active-high reset, sampled on slow_clk.
- result_ready  in  1  level; high while MMA results in memory are valid.
- element_count  in  ADDR_W+1  number of result elements (0..2^ADDR_W); sampled on leaving IDLE.
- pause  in  1  level; freezes dwell countdown.
- step  in  1  level, debounced; rising edge advances one element.
- rd_en  out  1  one-cycle read request to result memory.
- rd_addr  out  ADDR_W  read address; stable from rd_en until rd_valid.
- rd_data  in  32  read data, valid when rd_valid.
- rd_valid  in  1  read response strobe; arrives >= 1 cycle after rd_en.
- hex  out  32  value to display.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE, rd_en=0, rd_addr=0, hex=0, busy=0, dwell counter=0, index=0, step history=0.
- States:
  - IDLE: wait for result_ready=1 and element_count!=0, then latch count, set index=0, go to FETCH.
  - FETCH: drive rd_en=1 for exactly the first cycle, with rd_addr=index; wait in WAIT.
  - WAIT: on rd_valid, register hex from rd_data (see Optional Feature), load dwell=DWELL-1, go to SHOW.
  - SHOW:
    - Each cycle with pause=0 and dwell>0, decrement dwell.
    - At dwell==0 (pause=0), go to NEXT.
    - A step rising edge (pause either level) goes to NEXT immediately.
  - NEXT: index = (index==count-1) ? 0 : index+1; go to FETCH.
- Latency: hex updates the cycle after rd_valid; element period = DWELL + fetch latency + 2 cycles.
- Wrap-around: after the last element, index returns to 0; an element_count of 1 re-fetches element 0 each period.
- result_ready falling in any non-IDLE state: next cycle state=IDLE, hex=0, rd_en=0. Any in-flight rd_valid is ignored.
- Priority (highest first):
  - reset.
  - result_ready=0.
  - step edge.
  - dwell expiry.
- step edge detection: step is registered once and compared to its previous value. Edges outside SHOW are discarded, not queued.
- rd_valid outside WAIT is ignored.
- element_count changes are ignored until the next pass through IDLE.
- Reset mid-fetch: return to IDLE immediately; an outstanding response is ignored.

Optional Feature:
- Macro: RESULT_DISPLAY_INDEX_EN.
- Defined: hex = {index[7:0], rd_data[23:0]}. The leftmost two digits show the element index and the value is truncated to 24 bits.
- Undefined: hex = rd_data unmodified.

Decomposition:
- Package mma_display_pkg:
  - state enum (IDLE, FETCH, WAIT, SHOW, NEXT).
  - default DWELL constant.
  - hex blank constant 32'h0.
- Sub-module rising_edge_detect: one-register edge detector on step; reusable for other board buttons.

Test Plan:
- Reset, then result_ready=1, element_count=3, memory {0x11111111, 0x22222222, 0x33333333}, 1-cycle read latency -> hex shows each word in sequence and wraps back to 0x11111111; per-element period = DWELL+3 cycles.
- Set pause=1 for 500 cycles during SHOW -> hex unchanged for the pause plus the remaining dwell; no rd_en pulses while paused.
- With pause=1, pulse step -> rd_en asserted within 2 cycles with rd_addr=index+1; hex updates after rd_valid.
- Drop result_ready in WAIT, then assert rd_valid -> state IDLE, hex=0, busy=0; late response does not change hex.
- With element_count=0 and result_ready=1 -> stays IDLE, rd_en never asserted, hex=0.
- With RESULT_DISPLAY_INDEX_EN defined, index 5 and data 0xDEADBEEF -> hex=0x05ADBEEF.

Source files
------------

// File: rtl/mma_display_pkg.sv
// Shared types and constants for the MMA result display path.
// The index-prefix display mode is selected with RESULT_DISPLAY_INDEX_EN.
package mma_display_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SHOW,
    NEXT
  } state_t;

  localparam int          DEFAULT_DWELL = 1000;
  localparam logic [31:0] HEX_BLANK     = 32'h0;

  // Leftmost two digits carry the element index, the rest the low data bits.
  function automatic logic [31:0] index_prefixed(input logic [7:0] idx,
                                                 input logic [31:0] data);
    return {idx, data[23:0]};
  endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// One-register rising-edge detector for debounced board buttons.
// Each bit of level is compared against its value on the previous slow_clk edge.
module rising_edge_detect #(
  parameter int WIDTH = 1
) (
  input  logic             slow_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] level_reg;

  always_ff @(posedge slow_clk) begin
    if (reset) begin
      level_reg <= '0;
    end else begin
      level_reg <= level;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rise
      assign rise[gi] = level[gi] & ~level_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/result_display_sequencer.sv
// Walks the MMA result memory, fetching one word per element and holding it on hex for DWELL ticks.
// Define RESULT_DISPLAY_INDEX_EN to show the element index in the two leftmost digits.
module result_display_sequencer
  import mma_display_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DWELL  = DEFAULT_DWELL
) (
  input  logic              slow_clk,
  input  logic              reset,
  input  logic              result_ready,
  input  logic [ADDR_W:0]   element_count,
  input  logic              pause,
  input  logic              step,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  input  logic              rd_valid,
  output logic [31:0]       hex,
  output logic              busy
);

  localparam int                DWELL_W    = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] INDEX_ONE  = ADDR_W'(1);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   index_reg, index_next;
  logic [ADDR_W:0]     count_reg, count_next;
  logic [DWELL_W-1:0]  dwell_reg, dwell_next;
  logic [31:0]         hex_reg, hex_next;

  logic                step_rise;
  logic                last_element;
  logic [31:0]         display_word;

  rising_edge_detect #(
    .WIDTH (1)
  ) u_step_edge (
    .slow_clk (slow_clk),
    .reset    (reset),
    .level    (step),
    .rise     (step_rise)
  );

`ifdef RESULT_DISPLAY_INDEX_EN
  assign display_word = index_prefixed(8'(index_reg), rd_data);
`else
  assign display_word = rd_data;
`endif

  assign last_element = ({1'b0, index_reg} == (count_reg - COUNT_ONE));

  always_ff @(posedge slow_clk) begin
    if (reset) begin
      state_reg <= IDLE;
      index_reg <= '0;
      count_reg <= '0;
      dwell_reg <= '0;
      hex_reg   <= HEX_BLANK;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      count_reg <= count_next;
      dwell_reg <= dwell_next;
      hex_reg   <= hex_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    count_next = count_reg;
    dwell_next = dwell_reg;
    hex_next   = hex_reg;

    case (state_reg)
      IDLE: begin
        if (result_ready && (element_count != '0)) begin
          count_next = element_count;
          index_next = '0;
          state_next = FETCH;
        end
      end

      FETCH: begin
        state_next = WAIT;
      end

      WAIT: begin
        if (rd_valid) begin
          hex_next   = display_word;
          dwell_next = DWELL_LOAD;
          state_next = SHOW;
        end
      end

      SHOW: begin
        // A manual step overrides both pause and the remaining dwell.
        if (step_rise) begin
          state_next = NEXT;
        end else if (!pause) begin
          if (dwell_reg == '0) begin
            state_next = NEXT;
          end else begin
            dwell_next = dwell_reg - DWELL_W'(1);
          end
        end
      end

      NEXT: begin
        index_next = last_element ? '0 : index_reg + INDEX_ONE;
        state_next = FETCH;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Losing valid results abandons the pass, including any read in flight.
    if ((state_reg != IDLE) && !result_ready) begin
      state_next = IDLE;
      hex_next   = HEX_BLANK;
    end
  end

  assign rd_en   = (state_reg == FETCH) && result_ready;
  assign rd_addr = index_reg;
  assign hex     = hex_reg;
  assign busy    = (state_reg != IDLE);

endmodule
